// File: rtl/pe_result_packer.sv
// pe_result_packer
//   Packs the 32-bit results streamed by matrix_pe into 512-bit lines of 16 lanes, queues the
//   lines in a small first-word-fall-through FIFO, and writes them back to NRAM over a
//   valid/ready port. Each line carries an auto-incrementing line address. Partial lines are
//   closed by flush_i and carry a lane mask.
//
// Ports
//   clk, rst_n    clock; asynchronous active-low reset
//   pe_result     result word from matrix_pe
//   pe_vld_i      single-cycle result strobe (no backpressure)
//   flush_i       closes the current partial line
//   base_load_i   loads the write line address from base_addr_i
//   base_addr_i   start line address
//   wb_data_o     packed line, lane k at bits [DATA_W*k +: DATA_W]
//   wb_mask_o     lane-valid mask of wb_data_o
//   wb_addr_o     NRAM line address of wb_data_o
//   wb_valid_o    line available (FIFO not empty)
//   wb_ready_i    NRAM accepts the line
//   lane_cnt_o    lanes filled in the line being packed
//   overflow_o    sticky: a line was dropped because the FIFO was full
//   busy_o        partial line pending or FIFO not empty
module pe_result_packer #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned LANES      = 16,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned ADDR_W     = 16,
  localparam int unsigned LINE_W    = DATA_W * LANES,
  localparam int unsigned IDX_W     = $clog2(LANES),
  localparam int unsigned CNT_W     = IDX_W + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] pe_result,
  input  logic              pe_vld_i,
  input  logic              flush_i,
  input  logic              base_load_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  output logic [LINE_W-1:0] wb_data_o,
  output logic [LANES-1:0]  wb_mask_o,
  output logic [ADDR_W-1:0] wb_addr_o,
  output logic              wb_valid_o,
  input  logic              wb_ready_i,
  output logic [CNT_W-1:0]  lane_cnt_o,
  output logic              overflow_o,
  output logic              busy_o
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

  // ---------------------------------------------------------------- packing
  logic [LANES-1:0][DATA_W-1:0] pack_data;
  logic [LANES-1:0][DATA_W-1:0] line_next;
  logic [LANES-1:0]             pack_mask;
  logic [LANES-1:0]             mask_next;
  logic [CNT_W-1:0]             lane_cnt;
  logic [ADDR_W-1:0]            wr_addr;
  logic                         push;
  logic                         last_lane;

  // The line being pushed includes a result arriving in the same cycle.
  always_comb begin
    line_next = pack_data;
    mask_next = pack_mask;
    if (pe_vld_i) begin
      line_next[lane_cnt[IDX_W-1:0]] = pe_result;
      mask_next[lane_cnt[IDX_W-1:0]] = 1'b1;
    end
  end

  assign last_lane = pe_vld_i && (lane_cnt == CNT_W'(LANES - 1));
  // A flush on the last lane is the ordinary full push; an empty flush does nothing.
  assign push      = last_lane || (flush_i && ((lane_cnt != '0) || pe_vld_i));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pack_data <= '0;
      pack_mask <= '0;
      lane_cnt  <= '0;
    end else if (push) begin
      pack_data <= '0;
      pack_mask <= '0;
      lane_cnt  <= '0;
    end else if (pe_vld_i) begin
      pack_data <= line_next;
      pack_mask <= mask_next;
      lane_cnt  <= lane_cnt + CNT_W'(1);
    end
  end

  // A same-cycle push keeps the old address and base_load wins without increment.
  // Dropped lines still consume an address so later lines keep theirs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_addr <= '0;
    end else if (base_load_i) begin
      wr_addr <= base_addr_i;
    end else if (push) begin
      wr_addr <= wr_addr + ADDR_W'(1);
    end
  end

  // ------------------------------------------------------------------- FIFO
  logic [LINE_W-1:0] data_mem [FIFO_DEPTH];
  logic [LANES-1:0]  mask_mem [FIFO_DEPTH];
  logic [ADDR_W-1:0] addr_mem [FIFO_DEPTH];
  logic [PTR_W:0]    wr_ptr;
  logic [PTR_W:0]    rd_ptr;
  logic              empty;
  logic              full;
  logic              pop;
  logic              accept;

  assign empty  = (wr_ptr == rd_ptr);
  assign full   = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                  (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign pop    = !empty && wb_ready_i;
  // When full, a simultaneous pop frees the slot being written.
  assign accept = push && (!full || pop);

  always_ff @(posedge clk) begin
    if (accept) begin
      data_mem[wr_ptr[PTR_W-1:0]] <= line_next;
      mask_mem[wr_ptr[PTR_W-1:0]] <= mask_next;
      addr_mem[wr_ptr[PTR_W-1:0]] <= wr_addr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      overflow_o <= 1'b0;
    end else begin
      if (accept) begin
        wr_ptr <= wr_ptr + (PTR_W+1)'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + (PTR_W+1)'(1);
      end
      if (push && !accept) begin
        overflow_o <= 1'b1;
      end
    end
  end

  // Outputs read as zero while the FIFO is empty so stale entries never show.
  assign wb_valid_o = !empty;
  assign wb_data_o  = empty ? '0 : data_mem[rd_ptr[PTR_W-1:0]];
  assign wb_mask_o  = empty ? '0 : mask_mem[rd_ptr[PTR_W-1:0]];
  assign wb_addr_o  = empty ? '0 : addr_mem[rd_ptr[PTR_W-1:0]];
  assign lane_cnt_o = lane_cnt;
  assign busy_o     = (lane_cnt != '0) || !empty;

endmodule
